// File: rtl/rng_pkg.sv
// Shared constants and types for the 16-bit XNOR LFSR stream checker.
// Holds the tap positions, the seed/lock-up words and the checker state enum.
package rng_pkg;

    localparam int TAP_A = 10;
    localparam int TAP_B = 12;
    localparam int TAP_C = 13;
    localparam int TAP_D = 15;

    localparam logic [15:0] LFSR_SEED   = 16'hA455;
    localparam logic [15:0] LFSR_LOCKUP = 16'hFFFF;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // Next output bit of the XNOR LFSR given its current 16-bit state.
    function automatic logic lfsr_next_bit(input logic [15:0] s);
        return ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream port bundle of the PRBS checker, including the FSM state for debug.
// Handshake: a bit on bit_in is consumed on every rising edge where en=1; there is no backpressure.
interface prbs_checker_if;
    import rng_pkg::*;

    logic        en;
    logic        bit_in;
    logic        clr_count;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    chk_state_t  state;

    modport master (
        output en, bit_in, clr_count,
        input  locked, err_pulse, err_count, state
    );

    modport slave (
        input  en, bit_in, clr_count,
        output locked, err_pulse, err_count, state
    );

endinterface

// File: rtl/prbs_checker_sat_counter16.sv
// 16-bit error counter that sticks at all-ones; clear wins over the old value
// but a simultaneous increment still lands as 1.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] count
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? 16'd1 : 16'd0;
        end else if (inc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for a 16-bit XNOR LFSR stream: searches for lock on the
// received bits, then flywheels its own prediction and counts/flags mismatches.
module prbs_checker
    import rng_pkg::*;
#(
    parameter int LOCK_MATCHES = 16,
    parameter int UNLOCK_ERRS  = 4,
    parameter int WINDOW       = 64
) (
    input logic           clk,
    input logic           rst,
    prbs_checker_if.slave bus
);

    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);

    chk_state_t     state_q, state_d;
    logic [15:0]    sh_q, sh_d;
    logic [4:0]     fill_q, fill_d;
    logic [MW-1:0]  match_q, match_d;
    logic [WW-1:0]  win_q, win_d;
    logic [EW-1:0]  win_err_q, win_err_d;
    logic           err_pulse_q, err_pulse_d;
    logic           pred;
    logic           wrap;
    logic [EW-1:0]  win_err_base;
    logic           err_inc;

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        fill_d       = fill_q;
        match_d      = match_q;
        win_d        = win_q;
        win_err_d    = win_err_q;
        err_pulse_d  = 1'b0;
        err_inc      = 1'b0;
        wrap         = 1'b0;
        win_err_base = win_err_q;
        pred         = lfsr_next_bit(sh_q);

        if (bus.en) begin
            case (state_q)
                SEARCH: begin
                    sh_d = {sh_q[14:0], bus.bit_in};
                    if (fill_q != 5'd16) begin
                        fill_d = fill_q + 5'd1;
                    end else if (sh_q == LFSR_LOCKUP) begin
                        // All-ones predicts itself forever; never trust it as lock.
                        match_d = '0;
                    end else if (bus.bit_in == pred) begin
                        if (match_q == MW'(LOCK_MATCHES - 1)) begin
                            state_d   = LOCKED;
                            match_d   = '0;
                            win_d     = '0;
                            win_err_d = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end

                LOCKED: begin
                    // Flywheel: feed back our own prediction so one bad input bit costs one error.
                    sh_d         = {sh_q[14:0], pred};
                    wrap         = (win_q == WW'(WINDOW - 1));
                    win_d        = wrap ? '0 : win_q + WW'(1);
                    win_err_base = wrap ? '0 : win_err_q;
                    win_err_d    = win_err_base;
                    if (bus.bit_in != pred) begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        if (win_err_base == EW'(UNLOCK_ERRS - 1)) begin
                            state_d   = SEARCH;
                            fill_d    = '0;
                            match_d   = '0;
                            win_d     = '0;
                            win_err_d = '0;
                        end else begin
                            win_err_d = win_err_base + EW'(1);
                        end
                    end
                end

                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            sh_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter16 u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (bus.clr_count),
        .count (bus.err_count)
    );

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single/burst errors, window wrap, reset,
// gated enable, lock-up stream, and counter saturation on the counter sub-module.
module tb_prbs_checker;
    import rng_pkg::*;

    logic clk;
    logic rst;
    logic sc_inc;
    logic sc_clr;
    logic [15:0] sc_count;

    int n_vec;
    int n_miss;
    int n_pulse;
    logic ever_locked;
    logic [15:0] g;

    prbs_checker_if bus();

    prbs_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sat_counter16 sc (
        .clk   (clk),
        .rst   (rst),
        .inc   (sc_inc),
        .clr   (sc_clr),
        .count (sc_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic b, input logic clr);
        @(negedge clk);
        bus.en        = 1'b1;
        bus.bit_in    = b;
        bus.clr_count = clr;
        @(posedge clk);
        #1;
        bus.en        = 1'b0;
        bus.clr_count = 1'b0;
        if (bus.err_pulse) n_pulse++;
        if (bus.locked) ever_locked = 1'b1;
    endtask

    // Reference generator: 16-bit XNOR LFSR, taps 10/12/13/15.
    task automatic gen_send(input logic inv, input logic clr);
        logic b;
        b = ~(g[10] ^ g[12] ^ g[13] ^ g[15]);
        g = {g[14:0], b};
        send(b ^ inv, clr);
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        bus.en        = 1'b0;
        bus.clr_count = clr;
        @(posedge clk);
        #1;
        bus.clr_count = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_vec("rst_locked", {15'd0, bus.locked}, 16'd0);
        check_vec("rst_err_pulse", {15'd0, bus.err_pulse}, 16'd0);
        check_vec("rst_err_count", bus.err_count, 16'd0);
        check_vec("rst_state", {15'd0, bus.state}, {15'd0, SEARCH});
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0; n_miss = 0; n_pulse = 0; ever_locked = 1'b0;
        bus.en = 1'b0; bus.bit_in = 1'b0; bus.clr_count = 1'b0;
        sc_inc = 1'b0; sc_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        pulse_reset();

        // Clean stream from seed: lock visible right after the 32nd accepted bit.
        g = LFSR_SEED;
        repeat (31) gen_send(1'b0, 1'b0);
        check_vec("pre_lock_31", {15'd0, bus.locked}, 16'd0);
        gen_send(1'b0, 1'b0);
        check_vec("lock_32", {15'd0, bus.locked}, 16'd1);
        check_vec("lock_state", {15'd0, bus.state}, {15'd0, LOCKED});
        check_vec("lock_errcnt", bus.err_count, 16'd0);

        // Single inverted bit at 100.
        repeat (67) gen_send(1'b0, 1'b0);
        n_pulse = 0;
        gen_send(1'b1, 1'b0);
        check_vec("one_err_pulse", {15'd0, bus.err_pulse}, 16'd1);
        check_vec("one_err_count", bus.err_count, 16'd1);
        check_vec("one_err_locked", {15'd0, bus.locked}, 16'd1);
        gen_send(1'b0, 1'b0);
        check_vec("one_err_pulse_end", {15'd0, bus.err_pulse}, 16'd0);
        repeat (59) gen_send(1'b0, 1'b0);
        check_vec("one_err_pulses", 16'(n_pulse), 16'd1);

        // Clear alone.
        idle(1'b1);
        check_vec("clr_alone", bus.err_count, 16'd0);
        check_vec("clr_keeps_lock", {15'd0, bus.locked}, 16'd1);

        // Four errors in the window 161..224: bits 165,170,175,180.
        for (int i = 161; i <= 179; i++) gen_send((i % 5) == 0, 1'b0);
        check_vec("three_errs_locked", {15'd0, bus.locked}, 16'd1);
        gen_send(1'b1, 1'b0);
        check_vec("unlock_locked", {15'd0, bus.locked}, 16'd0);
        check_vec("unlock_pulse", {15'd0, bus.err_pulse}, 16'd1);
        check_vec("unlock_count", bus.err_count, 16'd4);

        // Re-lock 32 bits later (bit 212).
        repeat (31) gen_send(1'b0, 1'b0);
        check_vec("relock_31", {15'd0, bus.locked}, 16'd0);
        gen_send(1'b0, 1'b0);
        check_vec("relock_32", {15'd0, bus.locked}, 16'd1);

        // Window wraps on bit 276: errors 273-275 old window, 276-279 new window.
        repeat (60) gen_send(1'b0, 1'b0);
        repeat (3) gen_send(1'b1, 1'b0);
        gen_send(1'b1, 1'b0);
        check_vec("wrap_err_locked", {15'd0, bus.locked}, 16'd1);
        repeat (2) gen_send(1'b1, 1'b0);
        check_vec("wrap_three_locked", {15'd0, bus.locked}, 16'd1);
        gen_send(1'b1, 1'b0);
        check_vec("wrap_unlock", {15'd0, bus.locked}, 16'd0);
        check_vec("wrap_count", bus.err_count, 16'd11);

        // Re-lock on bit 311.
        repeat (31) gen_send(1'b0, 1'b0);
        gen_send(1'b0, 1'b0);
        check_vec("relock2", {15'd0, bus.locked}, 16'd1);

        // Clear coincident with an error (bit 320), then 330 and 340.
        repeat (8) gen_send(1'b0, 1'b0);
        gen_send(1'b1, 1'b1);
        check_vec("clr_with_err", bus.err_count, 16'd1);
        repeat (9) gen_send(1'b0, 1'b0);
        gen_send(1'b1, 1'b0);
        repeat (9) gen_send(1'b0, 1'b0);
        gen_send(1'b1, 1'b0);
        check_vec("three_count", bus.err_count, 16'd3);
        check_vec("three_locked", {15'd0, bus.locked}, 16'd1);

        // Reset mid-lock, then relock with en toggling every other cycle.
        pulse_reset();
        for (int i = 0; i < 31; i++) begin
            gen_send(1'b0, 1'b0);
            idle(1'b0);
        end
        check_vec("gated_pre_lock", {15'd0, bus.locked}, 16'd0);
        gen_send(1'b0, 1'b0);
        check_vec("gated_lock", {15'd0, bus.locked}, 16'd1);
        check_vec("gated_errcnt", bus.err_count, 16'd0);
        gen_send(1'b1, 1'b0);
        check_vec("gated_err_pulse", {15'd0, bus.err_pulse}, 16'd1);
        idle(1'b0);
        check_vec("en0_pulse_drop", {15'd0, bus.err_pulse}, 16'd0);
        check_vec("gated_err_count", bus.err_count, 16'd1);

        // Constant-one stream parks the shadow in the lock-up state.
        pulse_reset();
        ever_locked = 1'b0;
        repeat (200) send(1'b1, 1'b0);
        check_vec("ones_never_locked", {15'd0, ever_locked}, 16'd0);
        check_vec("ones_errcnt", bus.err_count, 16'd0);

        // Saturation of the error counter.
        @(negedge clk);
        sc_inc = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check_vec("sat_65534", sc_count, 16'hFFFE);
        @(posedge clk);
        #1;
        check_vec("sat_65535", sc_count, 16'hFFFF);
        repeat (70000 - 65535) @(posedge clk);
        #1;
        check_vec("sat_70000", sc_count, 16'hFFFF);
        @(negedge clk);
        sc_clr = 1'b1;
        @(posedge clk);
        #1;
        check_vec("sat_clr_inc", sc_count, 16'd1);
        @(negedge clk);
        sc_inc = 1'b0;
        @(posedge clk);
        #1;
        check_vec("sat_clr_only", sc_count, 16'd0);
        @(negedge clk);
        sc_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
